// File: rtl/apb_reg_slave_pkg.sv
// apb_reg_slave_pkg
//   Shared definitions for the APB register responder:
//   - FSM state encoding (ST_IDLE / ST_WAIT / ST_DONE)
//   - register index constants (ID, CNT, first RW scratch register)
//   - decode_err(): classifies an access as illegal
package apb_reg_slave_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic [5:0] REG_ID      = 6'd0;
    localparam logic [5:0] REG_CNT     = 6'd1;
    localparam logic [5:0] REG_RW_BASE = 6'd2;

    // An access is illegal when it falls outside the register bank (upper
    // address bits set or word index past the last register) or when it
    // writes one of the read-only registers below REG_RW_BASE.
    function automatic logic decode_err(input logic [5:0]  widx,
                                        input logic        upper_nz,
                                        input logic        wr,
                                        input int unsigned num_regs);
        logic oob;
        logic ro_wr;
        oob   = ({26'd0, widx} >= num_regs);
        ro_wr = wr && (widx < REG_RW_BASE);
        return upper_nz || oob || ro_wr;
    endfunction

endpackage

// File: rtl/apb_reg_slave_rf.sv
// apb_reg_slave_rf
//   Register file behind the APB responder: the ID constant, the CNT
//   transfer counter and NUM_REGS-2 read/write scratch registers.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset (clears CNT and RW registers)
//   we_i     : write strobe for the RW register at waddr_i
//   waddr_i  : word index of the write
//   wdata_i  : write data
//   inc_i    : CNT increment strobe (one completed non-error transfer)
//   raddr_i  : word index for the combinational read mux
//   rdata_o  : read data (0 for indices that hold no register)
module apb_reg_slave_rf
    import apb_reg_slave_pkg::*;
#(
    parameter int              NUM_REGS = 8,
    parameter int              DW       = 32,
    parameter logic [DW-1:0]   ID_VALUE = 32'h0A9B_0001
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [5:0]    waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          inc_i,
    input  logic [5:0]    raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int NUM_RW = NUM_REGS - 2;

    logic [DW-1:0] rw_q [NUM_RW];
    logic [31:0]   cnt_q;
    logic [31:0]   cnt_d;

    // Counter wraps naturally from all-ones to zero.
    assign cnt_d = inc_i ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                rw_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < NUM_RW; i++) begin
                if (we_i && (waddr_i == 6'(i) + REG_RW_BASE)) begin
                    rw_q[i] <= wdata_i;
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        if (raddr_i == REG_ID) begin
            rdata_o = ID_VALUE;
        end else if (raddr_i == REG_CNT) begin
            rdata_o = DW'(cnt_q);
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (raddr_i == 6'(i) + REG_RW_BASE) begin
                    rdata_o = rw_q[i];
                end
            end
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// apb_reg_slave
//   APB completer answering transfers on psel[SLV_IDX] with a small bank
//   of 32-bit registers (ID, CNT, RW scratch). Inserts WAIT_STATES wait
//   cycles per transfer and reports illegal accesses on pslverr.
//   Build option: define APB_REG_SLAVE_PSLVERR_EN to drive pslverr; when
//   undefined pslverr is tied to 0 (illegal accesses are still blocked,
//   read back 0 and are not counted).
// Ports:
//   pclock  : clock, rising edge
//   preset  : synchronous active-high reset
//   paddr   : byte address (bits [1:0] ignored)
//   prwd    : 1 = write, 0 = read
//   pwdata  : write data
//   penable : access phase indicator
//   psel    : one-hot selects, only psel[SLV_IDX] is decoded
//   prdata  : registered read data, nonzero only in the pready cycle
//   pslverr : registered error response, only in the pready cycle
//   pready  : registered transfer-complete
module apb_reg_slave
    import apb_reg_slave_pkg::*;
#(
    parameter int          PADDR_WIDTH  = 32,
    parameter int          PWDATA_WIDTH = 32,
    parameter int          PRDATA_WIDTH = 32,
    parameter int          SLV_IDX      = 0,
    parameter int          NUM_REGS     = 8,
    parameter int          WAIT_STATES  = 0,
    parameter logic [31:0] ID_VALUE     = 32'h0A9B_0001
) (
    input  logic                    pclock,
    input  logic                    preset,
    input  logic [PADDR_WIDTH-1:0]  paddr,
    input  logic                    prwd,
    input  logic [PWDATA_WIDTH-1:0] pwdata,
    input  logic                    penable,
    input  logic [15:0]             psel,
    output logic [PRDATA_WIDTH-1:0] prdata,
    output logic                    pslverr,
    output logic                    pready
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    logic sel;
    logic setup;
    logic upper_nz;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [5:0]  widx_q, widx_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic        enter_done;

    logic                    pready_q, pready_d;
    logic [PRDATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [PRDATA_WIDTH-1:0] rf_rdata;
    logic                    done_ok;
    logic                    unused_ok;

    assign sel      = psel[SLV_IDX];
    assign setup    = sel & ~penable;
    assign upper_nz = |(paddr >> 8);

    // Byte-lane bits and the other slaves' selects are intentionally ignored.
    assign unused_ok = ^{paddr[1:0], psel};

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        widx_d     = widx_q;
        wr_d       = wr_q;
        err_d      = err_q;
        enter_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    widx_d = paddr[7:2];
                    wr_d   = prwd;
                    err_d  = decode_err(paddr[7:2], upper_nz, prwd, NUM_REGS);
                    if (WAIT_STATES == 0) begin
                        state_d    = ST_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!sel) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == 4'd0) begin
                    state_d    = ST_DONE;
                    enter_done = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response is computed on the edge into DONE from the decoded access
    // (widx_d/err_d are the setup-cycle decode when entering straight from
    // IDLE). Only legal reads return data.
    assign pready_d = enter_done;
    assign prdata_d = (enter_done && !wr_d && !err_d) ? rf_rdata : '0;

    // A transfer completes on the DONE edge only if the master is still
    // selecting us in the access phase.
    assign done_ok = (state_q == ST_DONE) & pready_q & sel & penable & ~err_q;

    always_ff @(posedge pclock) begin
        if (preset) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= '0;
            widx_q   <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            pready_q <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            widx_q   <= widx_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            pready_q <= pready_d;
            prdata_q <= prdata_d;
        end
    end

`ifdef APB_REG_SLAVE_PSLVERR_EN
    logic pslverr_q;

    always_ff @(posedge pclock) begin
        if (preset) begin
            pslverr_q <= 1'b0;
        end else begin
            pslverr_q <= enter_done & err_d;
        end
    end

    assign pslverr = pslverr_q;
`else
    assign pslverr = 1'b0;
`endif

    assign pready = pready_q;
    assign prdata = prdata_q;

    apb_reg_slave_rf #(
        .NUM_REGS (NUM_REGS),
        .DW       (PRDATA_WIDTH),
        .ID_VALUE (PRDATA_WIDTH'(ID_VALUE))
    ) u_rf (
        .clk_i   (pclock),
        .rst_i   (preset),
        .we_i    (done_ok & wr_q),
        .waddr_i (widx_q),
        .wdata_i (pwdata),
        .inc_i   (done_ok),
        .raddr_i (widx_d),
        .rdata_o (rf_rdata)
    );

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave
//   Two responders share one APB bus: slave 0 on psel[0] with no wait
//   states, slave 1 on psel[3] with three wait states. A transfer-level
//   model (register arrays and counters per slave) predicts every output
//   on every cycle; a few literal values pin the model.
module tb_apb_reg_slave;

`ifdef APB_REG_SLAVE_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [31:0] ID = 32'h0A9B_0001;

    logic        clk;
    logic        preset;
    logic [31:0] paddr;
    logic        prwd;
    logic [31:0] pwdata;
    logic        penable;
    logic [15:0] psel;
    logic [31:0] prdata0, prdata1;
    logic        pslverr0, pslverr1, pready0, pready1;

    apb_reg_slave #(.SLV_IDX(0), .NUM_REGS(8), .WAIT_STATES(0)) dut0 (
        .pclock(clk), .preset(preset), .paddr(paddr), .prwd(prwd), .pwdata(pwdata),
        .penable(penable), .psel(psel), .prdata(prdata0), .pslverr(pslverr0), .pready(pready0));

    apb_reg_slave #(.SLV_IDX(3), .NUM_REGS(8), .WAIT_STATES(3)) dut1 (
        .pclock(clk), .preset(preset), .paddr(paddr), .prwd(prwd), .pwdata(pwdata),
        .penable(penable), .psel(psel), .prdata(prdata1), .pslverr(pslverr1), .pready(pready1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state
    logic [31:0] mreg [2][64];
    logic [31:0] mcnt [2];

    // per-cycle expectations
    bit          chk_en;
    bit          exp_rdy [2];
    bit          exp_err [2];
    bit          rd_chk  [2];
    logic [31:0] exp_rd  [2];

    logic        rdy_v [2];
    logic        err_v [2];
    logic [31:0] rd_v  [2];
    assign rdy_v[0] = pready0;  assign rdy_v[1] = pready1;
    assign err_v[0] = pslverr0; assign err_v[1] = pslverr1;
    assign rd_v[0]  = prdata0;  assign rd_v[1]  = prdata1;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                total++;
                if (rdy_v[k] !== exp_rdy[k]) begin
                    bad++;
                    $display("FAIL pready s%0d t=%0t got %b want %b", k, $time, rdy_v[k], exp_rdy[k]);
                end
                total++;
                if (err_v[k] !== exp_err[k]) begin
                    bad++;
                    $display("FAIL pslverr s%0d t=%0t got %b want %b", k, $time, err_v[k], exp_err[k]);
                end
                if (rd_chk[k]) begin
                    total++;
                    if (rd_v[k] !== exp_rd[k]) begin
                        bad++;
                        $display("FAIL prdata s%0d t=%0t got %h want %h", k, $time, rd_v[k], exp_rd[k]);
                    end
                end
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic exp_zero();
        for (int k = 0; k < 2; k++) begin
            exp_rdy[k] = 1'b0;
            exp_err[k] = 1'b0;
            rd_chk[k]  = 1'b1;
            exp_rd[k]  = '0;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = '0;
            for (int i = 0; i < 64; i++) mreg[k][i] = '0;
        end
    endtask

    function automatic int sel_bit(input int s);
        return (s == 0) ? 0 : (s == 1) ? 3 : 7;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            psel = '0; penable = 1'b0;
            exp_zero();
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        preset = 1'b1; psel = '0; penable = 1'b0;
        exp_zero();
        @(posedge clk); #1;
        preset = 1'b0;
        model_clear();
        exp_zero();
    endtask

    // s: 0/1 target slave, 2 = a psel bit nobody decodes.
    // ab_mode: 0 none, 1 drop psel in access cycle ab_j, 2 assert preset there.
    task automatic xfer(input int s, input logic [31:0] addr, input bit wr,
                        input logic [31:0] wd, input int ab_mode, input int ab_j,
                        output logic [31:0] rd_o, output logic err_o);
        int          ws;
        logic [5:0]  widx;
        bit          err;
        logic [31:0] rv;
        ws   = (s == 1) ? 3 : 0;
        widx = addr[7:2];
        err  = ((addr >> 8) != 0) || (widx >= 6'd8) || (wr && widx < 6'd2);
        rv   = '0;
        if (s < 2) rv = (widx == 0) ? ID : (widx == 1) ? mcnt[s] : mreg[s][widx];
        rd_o  = '0;
        err_o = 1'b0;
        @(posedge clk); #1;
        psel    = 16'(1) << sel_bit(s);
        penable = 1'b0;
        paddr   = addr;
        prwd    = wr;
        pwdata  = wd;
        exp_zero();
        for (int j = 0; j <= ws; j++) begin
            @(posedge clk); #1;
            penable = 1'b1;
            exp_zero();
            if (s < 2 && j == ws) begin
                exp_rdy[s] = 1'b1;
                exp_err[s] = err & ERR_EN;
                rd_chk[s]  = !wr;
                exp_rd[s]  = (!wr && !err) ? rv : '0;
            end
            if (ab_mode != 0 && j == ab_j) begin
                if (ab_mode == 1) begin
                    psel = '0; penable = 1'b0;
                end else begin
                    preset = 1'b1;
                end
                @(posedge clk); #1;
                if (ab_mode == 2) begin
                    preset = 1'b0; psel = '0; penable = 1'b0;
                    model_clear();
                end
                exp_zero();
                return;
            end
        end
        @(negedge clk);
        if (s < 2) begin
            rd_o  = rd_v[s];
            err_o = err_v[s];
            if (!err) begin
                if (wr) mreg[s][widx] = wd;
                mcnt[s] = mcnt[s] + 32'd1;
            end
        end
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        preset = 1'b1; psel = '0; penable = 1'b0;
        paddr = '0; prwd = 1'b0; pwdata = '0;
        chk_en = 1'b0;
        exp_zero();
        model_clear();
        @(posedge clk);
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0;

        // ID read, zero wait states
        xfer(0, 32'h00, 1'b0, '0, 0, 0, rd, er);
        lit("id_read", rd, 32'h0A9B_0001);
        lit("id_err", {31'd0, er}, 32'd0);

        // write / read back / CNT
        do_reset();
        xfer(0, 32'h08, 1'b1, 32'hDEAD_BEEF, 0, 0, rd, er);
        xfer(0, 32'h08, 1'b0, '0, 0, 0, rd, er);
        lit("rw_readback", rd, 32'hDEAD_BEEF);
        xfer(0, 32'h04, 1'b0, '0, 0, 0, rd, er);
        lit("cnt_after_2", rd, 32'd2);

        // wait-state slave read
        xfer(1, 32'h0C, 1'b0, '0, 0, 0, rd, er);
        lit("ws3_read", rd, 32'd0);

        // illegal accesses
        xfer(0, 32'h04, 1'b1, 32'h1234_5678, 0, 0, rd, er);
        lit("cnt_wr_err", {31'd0, er}, {31'd0, ERR_EN});
        xfer(0, 32'h40, 1'b0, '0, 0, 0, rd, er);
        lit("oob_err", {31'd0, er}, {31'd0, ERR_EN});
        lit("oob_data", rd, 32'd0);
        xfer(0, 32'h04, 1'b0, '0, 0, 0, rd, er);
        lit("cnt_unchanged", rd, 32'd3);
        lit("mdl_cnt0", mcnt[0], 32'd4);

        // abort by psel drop, then by reset
        xfer(1, 32'h10, 1'b1, 32'h55, 1, 1, rd, er);
        xfer(1, 32'h10, 1'b0, '0, 0, 0, rd, er);
        lit("abort_no_write", rd, 32'd0);
        xfer(1, 32'h14, 1'b1, 32'h77, 2, 1, rd, er);
        xfer(1, 32'h14, 1'b0, '0, 0, 0, rd, er);
        lit("reset_no_write", rd, 32'd0);
        xfer(1, 32'h10, 1'b1, 32'hA5A5, 0, 0, rd, er);
        xfer(1, 32'h10, 1'b0, '0, 0, 0, rd, er);
        lit("post_abort_rw", rd, 32'hA5A5);
        xfer(1, 32'h04, 1'b0, '0, 0, 0, rd, er);
        lit("cnt1_after_reset", rd, 32'd3);

        // back-to-back writes
        do_reset();
        xfer(0, 32'h0C, 1'b1, 32'd1, 0, 0, rd, er);
        xfer(0, 32'h10, 1'b1, 32'd2, 0, 0, rd, er);
        xfer(0, 32'h04, 1'b0, '0, 0, 0, rd, er);
        lit("b2b_cnt", rd, 32'd2);
        xfer(0, 32'h10, 1'b0, '0, 0, 0, rd, er);
        lit("b2b_second", rd, 32'd2);
        idle(2);

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            int          s, r, ab_mode, ab_j;
            logic [5:0]  w;
            logic [31:0] a;
            bit          wr;
            s  = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
            w  = 6'($urandom_range(0, 9));
            a  = {24'h0, w, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 15) == 0) a[$urandom_range(8, 31)] = 1'b1;
            wr = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 39));
            ab_mode = (r < 3) ? 1 : (r == 3) ? 2 : 0;
            ab_j    = int'($urandom_range(0, (s == 1) ? 3 : 0));
            xfer(s, a, wr, $urandom, ab_mode, ab_j, rd, er);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
